// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 front-end blocks.
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned WORDS   = 16;
  localparam int unsigned PTR_W   = 4;
  localparam int unsigned BYTES_W = 3;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_OUT  = 2'd1,
    ST_TAIL = 2'd2
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_insert.sv
// Keeps the first i_bytes bytes of a big-endian word, places the 0x80 terminator
// right after them and zeroes the rest; a full word passes through untouched.
module sha256_pad_insert
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0]  i_word,
  input  logic [BYTES_W-1:0] i_bytes,
  output logic [WORD_W-1:0]  o_word_c
);

  always_comb begin
    o_word_c = '0;
    for (int b = 0; b < 4; b++) begin
      if (BYTES_W'(b) < i_bytes) begin
        o_word_c[WORD_W-1-8*b -: 8] = i_word[WORD_W-1-8*b -: 8];
      end else if (BYTES_W'(b) == i_bytes) begin
        o_word_c[WORD_W-1-8*b -: 8] = PAD_BYTE;
      end
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Packs 32-bit message words into FIPS 180-4 padded 512-bit blocks, emitting an
// extra length-only block when the terminator or length does not fit.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64,
  parameter int unsigned IDX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [WORD_W-1:0]    i_data,
  input  logic [BYTES_W-1:0]   i_bytes,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [BLOCK_W-1:0]   o_block,
  output logic                 o_last,
  output logic [IDX_W-1:0]     o_blk_idx
);

  pad_state_t          r_state;
  pad_state_t          w_state_nxt;
  logic [WORD_W-1:0]   r_buf [WORDS];
  logic [PTR_W-1:0]    r_ptr;
  logic [LEN_W-1:0]    r_len;
  logic                r_tail_pend;
  logic                r_pend80;
  logic                r_last;
  logic [IDX_W-1:0]    r_idx;

  logic                w_in_fire;
  logic                w_full_word;
  logic [PTR_W:0]      w_term_idx;
  logic [LEN_W-1:0]    w_len_nxt;
  logic [WORD_W-1:0]   w_pad_word;

  assign i_ready     = (r_state == ST_LOAD);
  assign o_valid     = (r_state == ST_OUT);
  assign o_last      = r_last;
  assign o_blk_idx   = r_idx;

  assign w_in_fire   = i_valid && i_ready;
  assign w_full_word = (i_bytes == BYTES_W'(4));
  assign w_len_nxt   = r_len + LEN_W'({i_bytes, 3'b000});
  // Word that receives the terminator: a full last word pushes it into the next one.
  assign w_term_idx  = {1'b0, r_ptr} + (PTR_W+1)'(w_full_word);

  sha256_pad_insert u_pad_insert (
    .i_word   (i_data),
    .i_bytes  (i_bytes),
    .o_word_c (w_pad_word)
  );

  always_comb begin
    o_block = '0;
    for (int i = 0; i < WORDS; i++) begin
      o_block[BLOCK_W-1-WORD_W*i -: WORD_W] = r_buf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_in_fire && (i_last || (r_ptr == PTR_W'(WORDS-1)))) begin
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (o_ready) begin
          w_state_nxt = r_tail_pend ? ST_TAIL : ST_LOAD;
        end
      end
      ST_TAIL: w_state_nxt = ST_OUT;
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        r_buf[i] <= '0;
      end
      r_ptr       <= '0;
      r_len       <= '0;
      r_tail_pend <= 1'b0;
      r_pend80    <= 1'b0;
      r_last      <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_ptr <= r_ptr + PTR_W'(1);
            r_len <= w_len_nxt;
            if (!i_last) begin
              r_buf[r_ptr] <= i_data;
            end else begin
              r_buf[r_ptr] <= w_pad_word;
              if (w_full_word && (r_ptr != PTR_W'(WORDS-1))) begin
                r_buf[r_ptr + PTR_W'(1)] <= {PAD_BYTE, 24'h0};
              end
              if (w_term_idx <= (PTR_W+1)'(WORDS-3)) begin
                r_buf[WORDS-2] <= w_len_nxt[LEN_W-1 -: WORD_W];
                r_buf[WORDS-1] <= w_len_nxt[WORD_W-1:0];
                r_last         <= 1'b1;
              end else begin
                r_tail_pend <= 1'b1;
                r_pend80    <= w_full_word && (r_ptr == PTR_W'(WORDS-1));
              end
            end
          end
        end
        ST_OUT: begin
          if (o_ready) begin
            for (int i = 0; i < WORDS; i++) begin
              r_buf[i] <= '0;
            end
            r_ptr <= '0;
            r_idx <= r_last ? '0 : r_idx + IDX_W'(1);
            if (r_last) begin
              r_len  <= '0;
              r_last <= 1'b0;
            end
          end
        end
        ST_TAIL: begin
          // Buffer was cleared on the previous handshake; only terminator and length remain.
          r_buf[0]       <= r_pend80 ? {PAD_BYTE, 24'h0} : '0;
          r_buf[WORDS-2] <= r_len[LEN_W-1 -: WORD_W];
          r_buf[WORDS-1] <= r_len[WORD_W-1:0];
          r_last         <= 1'b1;
          r_tail_pend    <= 1'b0;
          r_pend80       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: table of messages with hand-padded blocks,
// plus backpressure and reset-abort sequences.
module tb_sha256_msg_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         i_ready;
  logic [31:0]  i_data;
  logic [2:0]   i_bytes;
  logic         i_last;
  logic         o_valid;
  logic         o_ready;
  logic [511:0] o_block;
  logic         o_last;
  logic [7:0]   o_blk_idx;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [511:0] msg;
    logic [4:0]   nwords;
    logic [2:0]   last_bytes;
    logic [1:0]   nblk;
    logic [511:0] exp0;
    logic [511:0] exp1;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  sha256_msg_padder #(.LEN_W(64), .IDX_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_data    (i_data),
    .i_bytes   (i_bytes),
    .i_last    (i_last),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_block   (o_block),
    .o_last    (o_last),
    .o_blk_idx (o_blk_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_valid && i_ready) begin
      assert (i_bytes <= 3'd4 && (i_last || i_bytes == 3'd4))
        else $error("illegal i_bytes %0d last %0b", i_bytes, i_last);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [511:0] msg, input int nw, input int lb,
                              input int nb, input logic [511:0] e0, input logic [511:0] e1);
    vec_t v;
    v.msg        = msg;
    v.nwords     = 5'(nw);
    v.last_bytes = 3'(lb);
    v.nblk       = 2'(nb);
    v.exp0       = e0;
    v.exp1       = e1;
    return v;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic [2:0] b, input logic l);
    int n = 0;
    while (!i_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!i_ready) chk("send_timeout", 512'd0, 512'd1);
    i_valid = 1'b1;
    i_data  = d;
    i_bytes = b;
    i_last  = l;
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic get_block(input string name, input logic [511:0] eb, input logic el,
                           input logic [7:0] ei);
    int n = 0;
    while (!o_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_valid"}, 512'(o_valid), 512'd1);
    chk({name, "_block"}, o_block, eb);
    chk({name, "_last"},  512'(o_last), 512'(el));
    chk({name, "_idx"},   512'(o_blk_idx), 512'(ei));
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
  endtask

  task automatic send_msg(input vec_t cur, input int upto);
    for (int w = 0; w < upto; w++) begin
      send_beat(cur.msg[511-32*w -: 32],
                (w == int'(cur.nwords) - 1) ? cur.last_bytes : 3'd4,
                w == int'(cur.nwords) - 1);
    end
  endtask

  task automatic run_vector(input int v);
    vec_t cur;
    cur = vecs[v];
    send_msg(cur, int'(cur.nwords));
    chk($sformatf("v%0d_latency", v), 512'(o_valid), 512'd1);
    get_block($sformatf("v%0d_b0", v), cur.exp0, cur.nblk == 2'd1, 8'd0);
    if (cur.nblk == 2'd2) get_block($sformatf("v%0d_b1", v), cur.exp1, 1'b1, 8'd1);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_i_ready"}, 512'(i_ready), 512'd1);
    chk({name, "_o_valid"}, 512'(o_valid), 512'd0);
    chk({name, "_o_last"},  512'(o_last), 512'd0);
    chk({name, "_idx"},     512'(o_blk_idx), 512'd0);
    chk({name, "_block"},   o_block, 512'd0);
  endtask

  initial begin
    logic [447:0] w56;
    w56 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
           32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
           32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};

    // "abc" with a junk low byte that must be dropped
    vecs[0] = mk({32'h616263FF, 480'h0}, 1, 3, 1,
                 {32'h61626380, {14{32'h0}}, 32'h00000018}, 512'h0);
    vecs[1] = mk(512'h0, 1, 0, 1, {32'h80000000, {15{32'h0}}}, 512'h0);
    vecs[2] = mk({32'h61626364, 480'h0}, 1, 4, 1,
                 {32'h61626364, 32'h80000000, {13{32'h0}}, 32'h00000020}, 512'h0);
    vecs[3] = mk({{13{32'h01020304}}, 96'h0}, 13, 4, 1,
                 {{13{32'h01020304}}, 32'h80000000, 32'h0, 32'h000001A0}, 512'h0);
    vecs[4] = mk({w56, 64'h0}, 14, 4, 2,
                 {w56, 32'h80000000, 32'h0}, {{15{32'h0}}, 32'h000001C0});
    vecs[5] = mk({{14{32'hDEADBEEF}}, 32'hCAFEBAEE, 32'h0}, 15, 3, 2,
                 {{14{32'hDEADBEEF}}, 32'hCAFEBA80, 32'h0}, {{15{32'h0}}, 32'h000001D8});
    vecs[6] = mk({16{32'hA5A5A5A5}}, 16, 4, 2,
                 {16{32'hA5A5A5A5}}, {32'h80000000, {14{32'h0}}, 32'h00000200});

    rst = 1'b1; i_valid = 1'b0; i_data = '0; i_bytes = '0; i_last = 1'b0; o_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_state("reset");

    for (int v = 0; v < NV; v++) run_vector(v);

    // Backpressure: block held 5 cycles while junk words are offered
    send_msg(vecs[6], 16);
    i_valid = 1'b1; i_data = 32'hBAD0BAD0; i_bytes = 3'd4; i_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_block", c), o_block, vecs[6].exp0);
      chk($sformatf("bp%0d_idx", c), 512'(o_blk_idx), 512'd0);
      chk($sformatf("bp%0d_i_ready", c), 512'(i_ready), 512'd0);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    get_block("bp_b0", vecs[6].exp0, 1'b0, 8'd0);
    get_block("bp_b1", vecs[6].exp1, 1'b1, 8'd1);
    run_vector(0);

    // Reset mid-message after 7 words
    send_msg(vecs[6], 7);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    chk_reset_state("rst_mid_msg");
    run_vector(0);

    // Reset while a block is being offered
    send_msg(vecs[2], 1);
    chk("rst_out_pre_valid", 512'(o_valid), 512'd1);
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    chk_reset_state("rst_mid_out");
    run_vector(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
